// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory program loader.
// Holds the loader state encoding, the stream/word widths, and the
// byte-order and checksum helpers used by the loader FSM.
package imem_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    // Loader states, 3-bit encoding shared with anything that inspects the FSM.
    typedef enum logic [2:0] {
        LD_IDLE    = 3'd0,
        LD_LEN_HI  = 3'd1,
        LD_LEN_LO  = 3'd2,
        LD_DATA_HI = 3'd3,
        LD_DATA_LO = 3'd4,
        LD_CSUM    = 3'd5,
        LD_DONE    = 3'd6,
        LD_ERR     = 3'd7
    } ld_state_e;

    // Frame words arrive high byte first; this is the only place that order lives.
    function automatic logic [WORD_W-1:0] word_assemble(
        input logic [BYTE_W-1:0] first_byte,
        input logic [BYTE_W-1:0] second_byte
    );
        word_assemble = {first_byte, second_byte};
    endfunction

    // Running frame checksum: plain XOR of every accepted byte.
    function automatic logic [BYTE_W-1:0] csum_update(
        input logic [BYTE_W-1:0] csum,
        input logic [BYTE_W-1:0] data
    );
        csum_update = csum ^ data;
    endfunction

    // States in which the loader is willing to take a stream byte.
    function automatic logic state_accepts_byte(input ld_state_e st);
        case (st)
            LD_LEN_HI, LD_LEN_LO, LD_DATA_HI, LD_DATA_LO, LD_CSUM:
                state_accepts_byte = 1'b1;
            default:
                state_accepts_byte = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte-stream link into the program loader (valid/ready handshake).
// The host drives valid/byte; the loader answers with ready.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic              in_valid;
    logic [BYTE_W-1:0] in_byte;
    logic              in_ready;

    modport master (output in_valid, output in_byte, input in_ready);
    modport slave  (input in_valid, input in_byte, output in_ready);

endinterface

// File: rtl/imem_loader.sv
// Program loader: assembles a framed byte stream into 16-bit words, writes
// them sequentially into imem and keeps the processor in reset until a frame
// with a matching XOR checksum has been fully loaded.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    imem_loader_if.slave      lnk,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [16:0]       MAX_W_17 = 17'(MAX_WORDS);

    ld_state_e         state_r, state_s;
    logic [15:0]       len_r, len_s;
    logic [BYTE_W-1:0] hi_r, hi_s;
    logic [15:0]       count_r, count_s;
    logic [BYTE_W-1:0] csum_r, csum_s;
    logic              in_ready_r, in_ready_s;
    logic              imem_we_r, imem_we_s;
    logic [ADDR_W-1:0] imem_waddr_r, imem_waddr_s;
    logic [WORD_W-1:0] imem_wdata_r, imem_wdata_s;
    logic              cpu_hold_r, cpu_hold_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              err_r, err_s;

    logic              accept_s;
    logic [15:0]       n_s;
    logic [15:0]       count_inc_s;

    assign accept_s    = lnk.in_valid & in_ready_r;
    assign n_s         = {len_r[15:8], lnk.in_byte};
    assign count_inc_s = count_r + 16'd1;

    assign lnk.in_ready = in_ready_r;
    assign imem_we      = imem_we_r;
    assign imem_waddr   = imem_waddr_r;
    assign imem_wdata   = imem_wdata_r;
    assign cpu_hold     = cpu_hold_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign err          = err_r;

    // Next-state and next-output logic for the frame parser.
    always_comb begin
        state_s      = state_r;
        len_s        = len_r;
        hi_s         = hi_r;
        count_s      = count_r;
        csum_s       = csum_r;
        imem_we_s    = 1'b0;
        imem_waddr_s = imem_waddr_r;
        imem_wdata_s = imem_wdata_r;
        cpu_hold_s   = cpu_hold_r;
        busy_s       = busy_r;
        done_s       = done_r;
        err_s        = err_r;

        case (state_r)
            LD_IDLE, LD_DONE, LD_ERR: begin
                if (start) begin
                    state_s    = LD_LEN_HI;
                    csum_s     = 8'h00;
                    count_s    = 16'd0;
                    done_s     = 1'b0;
                    err_s      = 1'b0;
                    busy_s     = 1'b1;
                    cpu_hold_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            LD_LEN_HI: begin
                if (accept_s) begin
                    len_s   = {lnk.in_byte, 8'h00};
                    csum_s  = csum_update(csum_r, lnk.in_byte);
                    state_s = LD_LEN_LO;
                end else begin
                    state_s = state_r;
                end
            end
            LD_LEN_LO: begin
                if (accept_s) begin
                    len_s  = n_s;
                    csum_s = csum_update(csum_r, lnk.in_byte);
                    if ({1'b0, n_s} > MAX_W_17) begin
                        state_s    = LD_ERR;
                        busy_s     = 1'b0;
                        err_s      = 1'b1;
                        cpu_hold_s = 1'b1;
                    end else if (n_s == 16'd0) begin
                        state_s = LD_CSUM;
                    end else begin
                        state_s = LD_DATA_HI;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            LD_DATA_HI: begin
                if (accept_s) begin
                    hi_s    = lnk.in_byte;
                    csum_s  = csum_update(csum_r, lnk.in_byte);
                    state_s = LD_DATA_LO;
                end else begin
                    state_s = state_r;
                end
            end
            LD_DATA_LO: begin
                if (accept_s) begin
                    csum_s       = csum_update(csum_r, lnk.in_byte);
                    imem_we_s    = 1'b1;
                    imem_wdata_s = word_assemble(hi_r, lnk.in_byte);
                    // Pre-increment count; address wraps at the write-port width.
                    imem_waddr_s = BASE_A + ADDR_W'(count_r);
                    count_s      = count_inc_s;
                    if (count_inc_s == len_r) begin
                        state_s = LD_CSUM;
                    end else begin
                        state_s = LD_DATA_HI;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            LD_CSUM: begin
                if (accept_s) begin
                    busy_s = 1'b0;
                    if (lnk.in_byte == csum_r) begin
                        state_s    = LD_DONE;
                        done_s     = 1'b1;
                        cpu_hold_s = 1'b0;
                    end else begin
                        state_s    = LD_ERR;
                        err_s      = 1'b1;
                        cpu_hold_s = 1'b1;
                    end
                    csum_s = csum_update(csum_r, lnk.in_byte);
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = LD_IDLE;
            end
        endcase

        // Ready follows the state being entered, so it is a pure register output.
        in_ready_s = state_accepts_byte(state_s);
    end

    // State and registered-output update; async reset discards any partial frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= LD_IDLE;
            len_r        <= 16'd0;
            hi_r         <= 8'h00;
            count_r      <= 16'd0;
            csum_r       <= 8'h00;
            in_ready_r   <= 1'b0;
            imem_we_r    <= 1'b0;
            imem_waddr_r <= BASE_A;
            imem_wdata_r <= 16'h0000;
            cpu_hold_r   <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            len_r        <= len_s;
            hi_r         <= hi_s;
            count_r      <= count_s;
            csum_r       <= csum_s;
            in_ready_r   <= in_ready_s;
            imem_we_r    <= imem_we_s;
            imem_waddr_r <= imem_waddr_s;
            imem_wdata_r <= imem_wdata_s;
            cpu_hold_r   <= cpu_hold_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            err_r        <= err_s;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for the program loader: frames with hand-computed writes
// and final status, backpressure gaps, length limit and mid-frame reset.
module tb_imem_loader;
    import imem_loader_pkg::*;

    typedef logic [7:0] byte_q_t[$];

    logic        clk;
    logic        rst;
    logic        start;
    logic        imem_we;
    logic [15:0] imem_waddr;
    logic [15:0] imem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks;
    int n_fails;
    int acc_cnt;
    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];

    imem_loader_if lif ();

    imem_loader #(.ADDR_W(16), .BASE_ADDR(0), .MAX_WORDS(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .lnk        (lif.slave),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record imem writes and accepted bytes, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(imem_waddr);
            wr_data_q.push_back(imem_wdata);
        end
        if (rst && lif.in_valid && lif.in_ready) begin
            acc_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        acc_cnt = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present one byte after 'gap' idle cycles and wait (bounded) for acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit taken;
        for (int g = 0; g < gap; g++) begin
            lif.in_valid = 1'b0;
            lif.in_byte  = 8'hFF;
            @(posedge clk); #1;
        end
        lif.in_valid = 1'b1;
        lif.in_byte  = b;
        taken = 1'b0;
        for (int c = 0; c < 16 && !taken; c++) begin
            if (lif.in_ready) taken = 1'b1;
            @(posedge clk); #1;
        end
        if (!taken) check_eq("rdy_timeout", {31'd0, lif.in_ready}, 32'd1);
    endtask

    task automatic send_frame(input byte_q_t bytes, input int gap);
        foreach (bytes[i]) send_byte(bytes[i], gap);
        lif.in_valid = 1'b0;
        lif.in_byte  = 8'h00;
    endtask

    task automatic check_status(input string pfx, input logic e_done, input logic e_err,
                                input logic e_hold, input logic e_busy, input logic e_rdy);
        check_eq({pfx, "_done"}, {31'd0, done}, {31'd0, e_done});
        check_eq({pfx, "_err"},  {31'd0, err},  {31'd0, e_err});
        check_eq({pfx, "_hold"}, {31'd0, cpu_hold}, {31'd0, e_hold});
        check_eq({pfx, "_busy"}, {31'd0, busy}, {31'd0, e_busy});
        check_eq({pfx, "_rdy"},  {31'd0, lif.in_ready}, {31'd0, e_rdy});
    endtask

    task automatic check_two_writes(input string pfx);
        check_eq({pfx, "_nwr"}, wr_addr_q.size(), 32'd2);
        if (wr_addr_q.size() >= 2) begin
            check_eq({pfx, "_a0"}, {16'd0, wr_addr_q[0]}, 32'h0000);
            check_eq({pfx, "_d0"}, {16'd0, wr_data_q[0]}, 32'h1234);
            check_eq({pfx, "_a1"}, {16'd0, wr_addr_q[1]}, 32'h0001);
            check_eq({pfx, "_d1"}, {16'd0, wr_data_q[1]}, 32'hABCD);
        end
    endtask

    // Directed sequence of loads.
    initial begin
        byte_q_t good_f, bad_f, over_f, zero_f;
        n_checks = 0;
        n_fails  = 0;
        acc_cnt  = 0;
        good_f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        bad_f  = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        over_f = '{8'h04, 8'h01};
        zero_f = '{8'h00, 8'h00, 8'h00};

        start        = 1'b0;
        lif.in_valid = 1'b0;
        lif.in_byte  = 8'h00;
        rst          = 1'b1;
        #1 rst = 1'b0;
        #2;
        check_status("rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("rst_we",    {31'd0, imem_we}, 32'd0);
        check_eq("rst_waddr", {16'd0, imem_waddr}, 32'd0);
        check_eq("rst_wdata", {16'd0, imem_wdata}, 32'd0);
        #9 rst = 1'b1;
        @(posedge clk); #1;

        // Basic load, in_valid held high.
        clear_log();
        do_start();
        check_status("bas_st", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        send_frame(good_f, 0);
        @(posedge clk); #1;
        check_two_writes("bas");
        check_status("bas", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("bas_acc", acc_cnt, 32'd7);

        // Bad checksum, started from DONE: hold re-asserts right after start.
        clear_log();
        do_start();
        check_status("bad_st", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        send_frame(bad_f, 0);
        @(posedge clk); #1;
        check_two_writes("bad");
        check_status("bad", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Length over limit: error right after the second length byte.
        clear_log();
        do_start();
        send_frame(over_f, 0);
        check_status("ovr", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("ovr_nwr", wr_addr_q.size(), 32'd0);
        check_eq("ovr_acc", acc_cnt, 32'd2);

        // Exactly MAX_WORDS is accepted as a length: still waiting for data.
        clear_log();
        do_start();
        send_frame('{8'h04, 8'h00}, 0);
        check_status("max", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk); #1;

        // Zero-length frame.
        clear_log();
        do_start();
        send_frame(zero_f, 0);
        @(posedge clk); #1;
        check_eq("zero_nwr", wr_addr_q.size(), 32'd0);
        check_status("zero", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Backpressure: three idle cycles before every byte.
        clear_log();
        do_start();
        send_frame(good_f, 3);
        @(posedge clk); #1;
        check_two_writes("gap");
        check_status("gap", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("gap_acc", acc_cnt, 32'd7);

        // Reset between the high and low bytes of the first word.
        clear_log();
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        lif.in_valid = 1'b1;
        lif.in_byte  = 8'h34;
        #2 rst = 1'b0;
        #1;
        check_status("mrst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("mrst_we",    {31'd0, imem_we}, 32'd0);
        check_eq("mrst_waddr", {16'd0, imem_waddr}, 32'd0);
        check_eq("mrst_wdata", {16'd0, imem_wdata}, 32'd0);
        lif.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("mrst_state", {29'd0, dut.state_r}, {29'd0, LD_IDLE});
        check_eq("mrst_hold",  {31'd0, cpu_hold}, 32'd1);
        check_eq("mrst_nwr",   wr_addr_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
